adder_tree_seq: RTL and testbench

Multi-beat reduction sequencer for the shared binary adder tree. It accepts a job descriptor (beat count, signed/unsigned mode), streams `NUM_INPUTS`-wide beats through one `adder_tree` instance, and accumulates the per-beat sums. It then presents a single wide result on a valid/ready output. It sits between the operand-fetch stream and the result writeback, and is the only block that drives the tree's `sign_unsign_ni` mode.

---
 rtl/swirl_pkg.sv | 25 ++
 rtl/adder_tree.sv | 64 ++++++
 rtl/adder_tree_seq.sv | 135 +++++++++++++
 tb/tb_adder_tree_seq.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/swirl_pkg.sv
// Shared types and width helpers for the adder-tree reduction blocks.
// ADDER_TREE_SEQ_PIPE_EN adds the DRAIN state to the sequencer FSM.
package swirl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
`ifdef ADDER_TREE_SEQ_PIPE_EN
    ST_DRAIN = 2'd2,
`endif
    ST_DONE  = 2'd3
  } adder_tree_seq_state_e;

  function automatic int tree_width(input int dataw, input int num_inputs);
    return dataw + $clog2(num_inputs);
  endfunction

  function automatic int acc_width(input int treew, input int max_beats);
    return treew + $clog2(max_beats);
  endfunction

  localparam int TREEW_DEF = tree_width(8, 8);
  localparam int ACCW_DEF  = acc_width(TREEW_DEF, 16);

endpackage

// File: rtl/adder_tree.sv
// Binary reduction tree: log2(NUM_INPUTS) cascaded layers, each widening by one
// bit with sign or zero extension selected by sign_unsign_ni (1 = signed).
module adder_tree_layer #(
  parameter int N_IN = 2,
  parameter int W_IN = 8
) (
  input  logic [N_IN-1:0][W_IN-1:0]   data_i,
  input  logic                        sign_unsign_ni,
  output logic [N_IN/2-1:0][W_IN:0]   data_o
);

  always_comb begin
    for (int i = 0; i < N_IN / 2; i++) begin
      data_o[i] = {sign_unsign_ni & data_i[2*i][W_IN-1], data_i[2*i]}
                + {sign_unsign_ni & data_i[2*i+1][W_IN-1], data_i[2*i+1]};
    end
  end

endmodule

module adder_tree
  import swirl_pkg::*;
#(
  parameter  int NUM_INPUTS = 8,
  parameter  int DATAW      = 8,
  localparam int TREEW      = tree_width(DATAW, NUM_INPUTS),
  localparam int LEVELS     = $clog2(NUM_INPUTS)
) (
  input  logic [DATAW-1:0] data_i [NUM_INPUTS],
  input  logic             sign_unsign_ni,
  output logic [TREEW-1:0] data_o
);

  logic [NUM_INPUTS-1:0][DATAW-1:0] leaf;

  always_comb begin
    for (int i = 0; i < NUM_INPUTS; i++) begin
      leaf[i] = data_i[i];
    end
  end

  for (genvar g = 0; g < LEVELS; g++) begin : g_lvl
    localparam int N_IN = NUM_INPUTS >> g;
    localparam int W_IN = DATAW + g;
    logic [N_IN/2-1:0][W_IN:0] sum;

    if (g == 0) begin : g_first
      adder_tree_layer #(.N_IN(N_IN), .W_IN(W_IN)) u_layer (
        .data_i         (leaf),
        .sign_unsign_ni (sign_unsign_ni),
        .data_o         (sum)
      );
    end else begin : g_next
      adder_tree_layer #(.N_IN(N_IN), .W_IN(W_IN)) u_layer (
        .data_i         (g_lvl[g-1].sum),
        .sign_unsign_ni (sign_unsign_ni),
        .data_o         (sum)
      );
    end
  end

  assign data_o = g_lvl[LEVELS-1].sum[0];

endmodule

// File: rtl/adder_tree_seq.sv
// Multi-beat reduction sequencer around one adder_tree; accumulates beat sums.
// ADDER_TREE_SEQ_PIPE_EN registers the tree output and adds a DRAIN state.
module adder_tree_seq
  import swirl_pkg::*;
#(
  parameter  int NUM_INPUTS = 8,
  parameter  int DATAW      = 8,
  parameter  int MAX_BEATS  = 16,
  localparam int TREEW      = tree_width(DATAW, NUM_INPUTS),
  localparam int BEATW      = $clog2(MAX_BEATS) + 1,
  localparam int ACCW       = acc_width(TREEW, MAX_BEATS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cfg_valid_i,
  output logic             cfg_ready_o,
  input  logic [BEATW-1:0] cfg_beats_i,
  input  logic             cfg_sign_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [DATAW-1:0] in_data_i [NUM_INPUTS],
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [ACCW-1:0]  out_data_o,
  output logic             busy_o
);

  adder_tree_seq_state_e state_q, state_d;
  logic                  sign_q, sign_d;
  logic [BEATW-1:0]      cnt_q, cnt_d;
  logic [ACCW-1:0]       acc_q, acc_d;
  logic [TREEW-1:0]      tree_sum;
  logic [ACCW-1:0]       acc_add;
  logic                  acc_add_en;
  logic                  cfg_hs, in_hs, out_hs;
  logic [BEATW-1:0]      beats_clamped;

  function automatic logic [ACCW-1:0] extend_sum(input logic [TREEW-1:0] s, input logic sgn);
    return {{(ACCW-TREEW){sgn & s[TREEW-1]}}, s};
  endfunction

  function automatic logic [BEATW-1:0] clamp_beats(input logic [BEATW-1:0] b);
    return (b > BEATW'(MAX_BEATS)) ? BEATW'(MAX_BEATS) : b;
  endfunction

  adder_tree #(.NUM_INPUTS(NUM_INPUTS), .DATAW(DATAW)) u_tree (
    .data_i         (in_data_i),
    .sign_unsign_ni (sign_q),
    .data_o         (tree_sum)
  );

  assign cfg_hs        = cfg_valid_i && (state_q == ST_IDLE);
  assign in_hs         = in_valid_i && (state_q == ST_RUN);
  assign out_hs        = out_ready_i && (state_q == ST_DONE);
  assign beats_clamped = clamp_beats(cfg_beats_i);

`ifdef ADDER_TREE_SEQ_PIPE_EN
  logic [TREEW-1:0] sum_p1_q;
  logic             vld_p1_q;

  // Stage p1: registered tree sum, folded into the accumulator one cycle later
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sum_p1_q <= '0;
      vld_p1_q <= 1'b0;
    end else begin
      vld_p1_q <= in_hs;
      if (in_hs) sum_p1_q <= tree_sum;
    end
  end

  assign acc_add    = extend_sum(sum_p1_q, sign_q);
  assign acc_add_en = vld_p1_q;
`else
  assign acc_add    = extend_sum(tree_sum, sign_q);
  assign acc_add_en = in_hs;
`endif

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    cnt_d   = cnt_q;
    acc_d   = acc_add_en ? (acc_q + acc_add) : acc_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cfg_hs) begin
          sign_d  = cfg_sign_i;
          acc_d   = '0;
          cnt_d   = beats_clamped;
          state_d = (beats_clamped == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (in_hs) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == BEATW'(1)) begin
`ifdef ADDER_TREE_SEQ_PIPE_EN
            state_d = ST_DRAIN;
`else
            state_d = ST_DONE;
`endif
          end
        end
      end
`ifdef ADDER_TREE_SEQ_PIPE_EN
      ST_DRAIN: state_d = ST_DONE;
`endif
      ST_DONE: begin
        if (out_hs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      sign_q  <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
    end
  end

  assign cfg_ready_o = (state_q == ST_IDLE);
  assign in_ready_o  = (state_q == ST_RUN);
  assign out_valid_o = (state_q == ST_DONE);
  assign busy_o      = (state_q != ST_IDLE);
  assign out_data_o  = acc_q;

endmodule

// File: tb/tb_adder_tree_seq.sv
// Scoreboard bench for adder_tree_seq: random and directed jobs against a plain
// arithmetic reference model; a monitor checks every result handshake.
module tb_adder_tree_seq;

  localparam int N     = 8;
  localparam int DW    = 8;
  localparam int MB    = 16;
  localparam int BEATW = 5;
  localparam int ACCW  = 15;
`ifdef ADDER_TREE_SEQ_PIPE_EN
  localparam int EXTRA_LAT = 1;
`else
  localparam int EXTRA_LAT = 0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [BEATW-1:0] cfg_beats;
  logic             cfg_sign;
  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    in_data [N];
  logic             out_valid;
  logic             out_ready;
  logic [ACCW-1:0]  out_data;
  logic             busy;

  int n_cmp = 0;
  int n_bad = 0;
  logic [ACCW-1:0] exp_q [$];
  logic [DW-1:0]   beat_mem [MB][N];
  int              bubbles [MB];

  adder_tree_seq #(.NUM_INPUTS(N), .DATAW(DW), .MAX_BEATS(MB)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cfg_valid_i (cfg_valid),
    .cfg_ready_o (cfg_ready),
    .cfg_beats_i (cfg_beats),
    .cfg_sign_i  (cfg_sign),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every result handshake pops one expected value
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_result: got 0x%0h, expected no result", out_data);
      end else begin
        check("result", longint'(out_data), longint'(exp_q.pop_front()));
      end
    end
  end

  task automatic send_cfg(input int beats, input bit sgn);
    int k = 0;
    cfg_valid = 1'b1;
    cfg_beats = BEATW'(beats);
    cfg_sign  = sgn;
    while (!cfg_ready && k < 100) begin
      tick();
      k++;
    end
    if (k >= 100) check("cfg_timeout", k, 0);
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic send_beat(input int b);
    int k = 0;
    for (int i = 0; i < bubbles[b]; i++) begin
      in_valid = 1'b0;
      tick();
    end
    in_valid = 1'b1;
    for (int e = 0; e < N; e++) in_data[e] = beat_mem[b][e];
    while (!in_ready && k < 100) begin
      tick();
      k++;
    end
    if (k >= 100) check("beat_timeout", k, 0);
    tick();
    in_valid = 1'b0;
  endtask

  // fill < 0: random elements; otherwise every element equals fill
  task automatic run_job(input int beats, input bit sgn, input int fill, input int hold, input bit rnd_bub);
    int n = (beats > MB) ? MB : beats;
    longint total = 0;
    logic [63:0] tot_bits;
    logic [DW-1:0] v;
    int k;
    for (int b = 0; b < n; b++) begin
      for (int e = 0; e < N; e++) begin
        v = (fill < 0) ? DW'($urandom_range(0, 255)) : DW'(fill);
        beat_mem[b][e] = v;
        if (sgn && v[DW-1]) total += longint'(v) - 256;
        else total += longint'(v);
      end
      if (rnd_bub) bubbles[b] = $urandom_range(0, 2);
    end
    tot_bits = total;
    exp_q.push_back(tot_bits[ACCW-1:0]);

    send_cfg(beats, sgn);
    check("busy_after_cfg", busy, 1);
    for (int b = 0; b < n; b++) send_beat(b);
    if (n > 0) check("in_ready_after_last", in_ready, 0);

    k = 0;
    while (!out_valid && k < 20) begin
      tick();
      k++;
    end
    check("latency", k, (n == 0) ? 0 : EXTRA_LAT);

    if (hold > 0) begin
      out_ready = 1'b0;
      for (int h = 0; h < hold; h++) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", longint'(out_data), longint'(tot_bits[ACCW-1:0]));
        check("hold_in_ready", in_ready, 0);
        check("hold_cfg_ready", cfg_ready, 0);
        cfg_valid = 1'b1;
        cfg_beats = 5'd3;
        in_valid  = 1'b1;
        for (int e = 0; e < N; e++) in_data[e] = DW'($urandom_range(0, 255));
        tick();
      end
      cfg_valid = 1'b0;
      in_valid  = 1'b0;
      check("hold_data_end", longint'(out_data), longint'(tot_bits[ACCW-1:0]));
    end else begin
      repeat ($urandom_range(0, 2)) tick();
    end

    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("idle_cfg_ready", cfg_ready, 1);
    check("idle_out_valid", out_valid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    cfg_valid = 1'b0;
    cfg_beats = '0;
    cfg_sign  = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    for (int e = 0; e < N; e++) in_data[e] = '0;
    for (int b = 0; b < MB; b++) bubbles[b] = 0;

    #7;
    check("rst_cfg_ready", cfg_ready, 1);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", longint'(out_data), 0);
    check("rst_busy", busy, 0);
    tick();
    rst = 1'b0;
    tick();

    run_job(2, 1'b0, 8'hFF, 0, 1'b0);
    run_job(1, 1'b1, 8'h80, 0, 1'b0);
    run_job(16, 1'b1, 8'h7F, 0, 1'b0);
    run_job(0, 1'b0, -1, 0, 1'b0);
    run_job(31, 1'b0, -1, 0, 1'b0);
    run_job(1, 1'b1, 8'h80, 5, 1'b0);

    bubbles[0] = 0;
    bubbles[1] = 2;
    bubbles[2] = 0;
    run_job(3, 1'b1, -1, 0, 1'b0);

    // Reset mid-job after 2 of 4 beats: no result may appear
    for (int b = 0; b < 4; b++) begin
      bubbles[b] = 0;
      for (int e = 0; e < N; e++) beat_mem[b][e] = DW'($urandom_range(0, 255));
    end
    send_cfg(4, 1'b0);
    send_beat(0);
    send_beat(1);
    #3;
    rst = 1'b1;
    #1;
    check("midrst_cfg_ready", cfg_ready, 1);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", longint'(out_data), 0);
    check("midrst_busy", busy, 0);
    tick();
    rst = 1'b0;
    tick();
    run_job(1, 1'b0, 1, 0, 1'b0);

    for (int j = 0; j < 25; j++) begin
      run_job($urandom_range(0, 20), 1'($urandom_range(0, 1)), -1, 0, 1'b1);
    end

    repeat (3) tick();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
